// File: rtl/netled_pkg.sv
// Shared netled definitions: LED source select codes and blink timer width.
package netled_pkg;

    typedef enum logic [1:0] {
        MODE_LIVE     = 2'd0,
        MODE_DEMO     = 2'd1,
        MODE_LAMPTEST = 2'd2,
        MODE_OFF      = 2'd3
    } mode_e;

    localparam int unsigned BLINK_TW = 8;

endpackage

// File: rtl/netled_blink.sv
// Per-link activity blink FSM: IDLE -> ON (BLINK_ON ticks) -> GAP (BLINK_OFF ticks),
// with one collapsed pending blink; held idle while the link is down.
module netled_blink
    import netled_pkg::*;
#(
    parameter logic [BLINK_TW-1:0] BLINK_ON  = 8'd50,
    parameter logic [BLINK_TW-1:0] BLINK_OFF = 8'd50
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_tick,
    input  logic i_linkup,
    input  logic i_activity,
    output logic o_on
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e              state_q;
    logic [BLINK_TW-1:0] timer_q;
    logic                pending_q;
    logic                pend_now;

    // A pulse landing on the GAP-exit tick must still count as pending.
    assign pend_now = pending_q | i_activity;

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_linkup) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_activity) begin
                        state_q <= ST_ON;
                        timer_q <= BLINK_ON;
                    end
                end
                ST_ON: begin
                    pending_q <= pend_now;
                    if (i_tick) begin
                        if (timer_q == BLINK_TW'(1)) begin
                            state_q <= ST_GAP;
                            timer_q <= BLINK_OFF;
                        end else begin
                            timer_q <= timer_q - BLINK_TW'(1);
                        end
                    end
                end
                ST_GAP: begin
                    pending_q <= pend_now;
                    if (i_tick) begin
                        if (timer_q == BLINK_TW'(1)) begin
                            state_q   <= pend_now ? ST_ON : ST_IDLE;
                            timer_q   <= pend_now ? BLINK_ON : '0;
                            pending_q <= 1'b0;
                        end else begin
                            timer_q <= timer_q - BLINK_TW'(1);
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    timer_q   <= '0;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_on = (state_q == ST_ON);

endmodule

// File: rtl/netled_ctrl.sv
// Network LED controller: shared blink-tick divider, per-link blink FSMs and a
// registered LED source mux (live / demo / lamp test / off).
module netled_ctrl
    import netled_pkg::*;
#(
    parameter int                  NLINKS    = 4,
    parameter int                  TICK_DIV  = 100_000,
    parameter logic [BLINK_TW-1:0] BLINK_ON  = 8'd50,
    parameter logic [BLINK_TW-1:0] BLINK_OFF = 8'd50
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [1:0]        i_mode,
    input  logic [NLINKS-1:0] i_linkup,
    input  logic [NLINKS-1:0] i_activity,
    input  logic [NLINKS-1:0] i_demo_linkup,
    input  logic [NLINKS-1:0] i_demo_activity,
    output logic [NLINKS-1:0] o_linkup,
    output logic [NLINKS-1:0] o_activity
);

    localparam int               CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick;
    logic [NLINKS-1:0] blink_on;
    logic [NLINKS-1:0] lu_q, lu_d;
    logic [NLINKS-1:0] act_q, act_d;

    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    for (genvar k = 0; k < NLINKS; k++) begin : g_link
        netled_blink #(
            .BLINK_ON  (BLINK_ON),
            .BLINK_OFF (BLINK_OFF)
        ) u_blink (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_tick     (tick),
            .i_linkup   (i_linkup[k]),
            .i_activity (i_activity[k]),
            .o_on       (blink_on[k])
        );
    end

    // The FSM returns to IDLE one edge after link loss; masking with the live
    // link bit darkens the activity LED on the same edge as the link LED.
    always_comb begin
        lu_d  = '0;
        act_d = '0;
        case (mode_e'(i_mode))
            MODE_LIVE: begin
                lu_d  = i_linkup;
                act_d = blink_on & i_linkup;
            end
            MODE_DEMO: begin
                lu_d  = i_demo_linkup;
                act_d = i_demo_activity;
            end
            MODE_LAMPTEST: begin
                lu_d  = '1;
                act_d = '1;
            end
            default: begin
                lu_d  = '0;
                act_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
            lu_q  <= '0;
            act_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            lu_q  <= lu_d;
            act_q <= act_d;
        end
    end

    assign o_linkup   = lu_q;
    assign o_activity = act_q;

endmodule

// File: tb/tb_netled_ctrl.sv
// Directed bench for netled_ctrl with TICK_DIV=4, BLINK_ON=3, BLINK_OFF=2, NLINKS=4.
module tb_netled_ctrl;

    logic       clk;
    logic       i_reset;
    logic [1:0] i_mode;
    logic [3:0] i_linkup;
    logic [3:0] i_activity;
    logic [3:0] i_demo_linkup;
    logic [3:0] i_demo_activity;
    logic [3:0] o_linkup;
    logic [3:0] o_activity;

    int vectors     = 0;
    int miscompares = 0;
    int n           = 0;   // edges since the last reset edge; ticks land on n = 4, 8, ...

    netled_ctrl #(
        .NLINKS    (4),
        .TICK_DIV  (4),
        .BLINK_ON  (8'd3),
        .BLINK_OFF (8'd2)
    ) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_mode          (i_mode),
        .i_linkup        (i_linkup),
        .i_activity      (i_activity),
        .i_demo_linkup   (i_demo_linkup),
        .i_demo_activity (i_demo_activity),
        .o_linkup        (o_linkup),
        .o_activity      (o_activity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        n++;
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int j = lo; j <= hi; j++) m[j] = 1'b1;
        return m;
    endfunction

    task automatic do_reset(input int cycles);
        i_reset = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        n       = 0;
        i_reset = 1'b0;
    endtask

    task automatic align(input int p);
        while ((n % 4) != p) step();
    endtask

    // Drive a per-offset schedule on link k starting from an edge a with a%4==3
    // (so a+1 is a tick edge); record o_*[k] after edges a+1..a+len in bits 1..len.
    task automatic run_seq(input int k, input logic [63:0] pulses, input logic [63:0] down,
                           input logic [1:0] pre_mode, input int live_at, input int len,
                           output logic [63:0] ract, output logic [63:0] rlu);
        ract   = '0;
        rlu    = '0;
        i_mode = pre_mode;
        align(3);
        for (int i = 0; i < len; i++) begin
            i_mode        = (i < live_at) ? pre_mode : 2'd0;
            i_activity    = '0;
            i_activity[k] = pulses[i];
            i_linkup      = 4'hF;
            i_linkup[k]   = ~down[i];
            step();
            ract[i+1] = o_activity[k];
            rlu[i+1]  = o_linkup[k];
        end
        i_activity = '0;
        i_linkup   = 4'hF;
        i_mode     = 2'd0;
    endtask

    initial begin
        logic [63:0] ract, rlu;
        int hits;

        i_reset         = 1'b0;
        i_mode          = 2'd0;
        i_linkup        = 4'hF;
        i_activity      = '0;
        i_demo_linkup   = '0;
        i_demo_activity = '0;

        do_reset(3);
        check("reset_linkup", 64'(o_linkup), 64'h0);
        check("reset_activity", 64'(o_activity), 64'h0);
        step();
        check("live_linkup", 64'(o_linkup), 64'hF);

        // Single blink on link 0 starting on a tick-aligned edge: 12 cycles lit.
        run_seq(0, 64'h1, 64'h0, 2'd0, 0, 48, ract, rlu);
        check("blink_act", ract, rng(2, 13));
        check("blink_lu", rlu, rng(1, 48));

        // Pulses in ON and twice in GAP: two blinks, 8-cycle gap, no third.
        run_seq(1, 64'h24011, 64'h0, 2'd0, 0, 48, ract, rlu);
        check("pending_act", ract, rng(2, 13) | rng(22, 33));
        check("pending_lu", rlu, rng(1, 48));

        // Pulse in the GAP-exit tick cycle goes straight back to ON.
        run_seq(3, 64'h100001, 64'h0, 2'd0, 0, 48, ract, rlu);
        check("gapexit_act", ract, rng(2, 13) | rng(22, 33));
        check("gapexit_lu", rlu, rng(1, 48));

        // One cycle later the FSM is already IDLE: new blink starts a cycle later.
        run_seq(3, 64'h200001, 64'h0, 2'd0, 0, 48, ract, rlu);
        check("after_gap_act", ract, rng(2, 13) | rng(23, 33));

        // Link 2 drops mid-ON with pending set; relink shows no blink.
        run_seq(2, 64'h9, 64'h3C0, 2'd0, 0, 48, ract, rlu);
        check("linkdrop_act", ract, rng(2, 6));
        check("linkdrop_lu", rlu, rng(1, 6) | rng(11, 48));

        // Source-select modes.
        i_mode          = 2'd1;
        i_demo_linkup   = 4'h5;
        i_demo_activity = 4'hA;
        step();
        check("demo_lu", 64'(o_linkup), 64'h5);
        check("demo_act", 64'(o_activity), 64'hA);
        i_mode = 2'd2;
        step();
        check("lamp_lu", 64'(o_linkup), 64'hF);
        check("lamp_act", 64'(o_activity), 64'hF);
        i_mode = 2'd3;
        step();
        check("off_lu", 64'(o_linkup), 64'h0);
        check("off_act", 64'(o_activity), 64'h0);
        i_demo_linkup   = '0;
        i_demo_activity = '0;

        // Blink starts while OFF; switching to LIVE shows its remaining duration.
        run_seq(0, 64'h1, 64'h0, 2'd3, 6, 24, ract, rlu);
        check("return_live_act", ract, rng(7, 13));
        check("return_live_lu", rlu, rng(7, 24));

        // Reset mid-blink with pending set.
        align(3);
        i_activity = 4'h1;
        step();
        i_activity = 4'h0;
        step();
        step();
        i_activity = 4'h1;
        step();
        i_activity = 4'h0;
        step();
        do_reset(1);
        check("midreset_lu", 64'(o_linkup), 64'h0);
        check("midreset_act", 64'(o_activity), 64'h0);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (o_activity != 4'h0) hits++;
        end
        check("midreset_noblink", 64'(hits), 64'h0);

        // Tick phase restarted by reset: aligned blink is again 12 cycles.
        run_seq(0, 64'h1, 64'h0, 2'd0, 0, 24, ract, rlu);
        check("post_reset_act", ract, rng(2, 13));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
